// File: rtl/rule_unit_arb.sv
// Purpose : round-robin arbiter sharing one fixed-latency rule_unit among NUM_REQ requesters,
//           with a tag pipeline that routes each match result back to the requester that issued it.
// Latency : beat accepted at N -> ru_* driven at T=N+1 -> rsp_valid/rsp_done at T+LATENCY+1.
// Backpressure: req_ready is the grant (one per cycle); a requester whose last beat is still in
//           flight (DRAIN) is held off until its rsp_done; responses have no backpressure.
// Ports   : clk/rst; req_* requester beats (valid/ready); ru_* issue to and results from the
//           rule_unit; rsp_* per-requester results and packet-done pulses; err_orphan sticky flag.
module rule_unit_arb #(
   parameter int NUM_REQ     = 4,
   parameter int RULE_AWIDTH = 16,
   parameter int LATENCY     = 18
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*RULE_AWIDTH-1:0] req_rule_data,
   input  logic [NUM_REQ*16-1:0]          req_src_port,
   input  logic [NUM_REQ*16-1:0]          req_dst_port,
   input  logic [NUM_REQ-1:0]             req_tcp,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [RULE_AWIDTH-1:0]         ru_rule_data,
   output logic                           ru_rule_valid,
   output logic [15:0]                    ru_src_port,
   output logic [15:0]                    ru_dst_port,
   output logic                           ru_tcp,
   input  logic [RULE_AWIDTH-1:0]         ru_out_rule_data,
   input  logic                           ru_rule_pg_match,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [NUM_REQ*RULE_AWIDTH-1:0] rsp_rule_data,
   output logic [NUM_REQ-1:0]             rsp_done,
   output logic                           err_orphan
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} st_e;

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
      logic           last;
   } tag_t;

   st_e            state [NUM_REQ];
   logic [IDW-1:0] last_grant;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic           gnt_any;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] issue_id;
   logic           issue_last;
   tag_t           tag_q [LATENCY];
   tag_t           tag_out;

   // Requester index at round-robin distance k past base (base+1+k mod NUM_REQ).
   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
      int t;
      t = int'(base) + 1 + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      return t[IDW-1:0];
   endfunction

   // Grant is combinational so a requester can transfer every cycle it is eligible.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = req_valid[i] && (state[i] != ST_DRAIN) && !rst;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt_any && elig[rr_idx(last_grant, k)]) begin
            gnt_any = 1'b1;
            gnt_id  = rr_idx(last_grant, k);
         end
      end
      if (gnt_any) gnt[gnt_id] = 1'b1;
   end

   assign req_ready = gnt;

   // Per-requester packet FSMs and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) state[i] <= ST_IDLE;
         last_grant <= IDW'(NUM_REQ - 1);
      end else begin
         if (gnt_any) last_grant <= gnt_id;
         for (int i = 0; i < NUM_REQ; i++) begin
            case (state[i])
               ST_IDLE, ST_ACTIVE:
                  if (gnt[i]) state[i] <= req_last[i] ? ST_DRAIN : ST_ACTIVE;
               // rsp_done is registered, so the requester becomes eligible the cycle after it.
               ST_DRAIN:
                  if (rsp_done[i]) state[i] <= ST_IDLE;
               default:
                  state[i] <= ST_IDLE;
            endcase
         end
      end
   end

   // Issue register toward the rule_unit; idle cycles drive zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         ru_rule_valid <= 1'b0;
         ru_rule_data  <= '0;
         ru_src_port   <= '0;
         ru_dst_port   <= '0;
         ru_tcp        <= 1'b0;
         issue_id      <= '0;
         issue_last    <= 1'b0;
      end else begin
         ru_rule_valid <= gnt_any;
         if (gnt_any) begin
            ru_rule_data <= req_rule_data[int'(gnt_id)*RULE_AWIDTH +: RULE_AWIDTH];
            ru_src_port  <= req_src_port[int'(gnt_id)*16 +: 16];
            ru_dst_port  <= req_dst_port[int'(gnt_id)*16 +: 16];
            ru_tcp       <= req_tcp[gnt_id];
            issue_id     <= gnt_id;
            issue_last   <= req_last[gnt_id];
         end else begin
            ru_rule_data <= '0;
            ru_src_port  <= '0;
            ru_dst_port  <= '0;
            ru_tcp       <= 1'b0;
            issue_id     <= '0;
            issue_last   <= 1'b0;
         end
      end
   end

   // Tag shift register mirrors the rule_unit pipeline: the tag loaded while ru_rule_valid
   // is high sits at the last stage exactly when that beat's match result arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0] <= '{vld: ru_rule_valid, id: issue_id, last: issue_last};
         for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   assign tag_out = tag_q[LATENCY-1];

   // Response fan-out; a match with no live tag (including pre-reset beats) is an orphan.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid     <= '0;
         rsp_rule_data <= '0;
         rsp_done      <= '0;
         err_orphan    <= 1'b0;
      end else begin
         rsp_valid     <= '0;
         rsp_rule_data <= '0;
         rsp_done      <= '0;
         if (tag_out.vld) begin
            if (ru_rule_pg_match) begin
               rsp_valid[tag_out.id] <= 1'b1;
               rsp_rule_data[int'(tag_out.id)*RULE_AWIDTH +: RULE_AWIDTH] <= ru_out_rule_data;
            end
            if (tag_out.last) rsp_done[tag_out.id] <= 1'b1;
         end else if (ru_rule_pg_match) begin
            err_orphan <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rule_unit_arb.sv
// Bench for rule_unit_arb: a delay-line model of the rule_unit, a table of round-robin
// vectors, and directed sequences for drain blocking, null rules, reset and orphans.
module tb_rule_unit_arb;

   localparam int N = 4;
   localparam int W = 16;
   localparam int L = 18;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_rule_data;
   logic [N*16-1:0] req_src_port;
   logic [N*16-1:0] req_dst_port;
   logic [N-1:0]   req_tcp;
   logic [N-1:0]   req_last;
   logic [W-1:0]   ru_rule_data;
   logic           ru_rule_valid;
   logic [15:0]    ru_src_port;
   logic [15:0]    ru_dst_port;
   logic           ru_tcp;
   logic [W-1:0]   ru_out_rule_data;
   logic           ru_rule_pg_match;
   logic [N-1:0]   rsp_valid;
   logic [N*W-1:0] rsp_rule_data;
   logic [N-1:0]   rsp_done;
   logic           err_orphan;

   logic match_en    = 1'b0;
   logic force_match = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rule_unit_arb #(.NUM_REQ(N), .RULE_AWIDTH(W), .LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rule_data(req_rule_data),
      .req_src_port(req_src_port), .req_dst_port(req_dst_port), .req_tcp(req_tcp),
      .req_last(req_last),
      .ru_rule_data(ru_rule_data), .ru_rule_valid(ru_rule_valid),
      .ru_src_port(ru_src_port), .ru_dst_port(ru_dst_port), .ru_tcp(ru_tcp),
      .ru_out_rule_data(ru_out_rule_data), .ru_rule_pg_match(ru_rule_pg_match),
      .rsp_valid(rsp_valid), .rsp_rule_data(rsp_rule_data), .rsp_done(rsp_done),
      .err_orphan(err_orphan)
   );

   // rule_unit model: fixed L-cycle delay, oblivious to rst; matches every issued beat when enabled.
   logic [L-1:0] mdl_vld = '0;
   logic [W-1:0] mdl_dat [L];
   always @(posedge clk) begin
      mdl_vld    <= {mdl_vld[L-2:0], ru_rule_valid};
      mdl_dat[0] <= ru_rule_data;
      for (int k = 1; k < L; k++) mdl_dat[k] <= mdl_dat[k-1];
   end
   assign ru_rule_pg_match = force_match | (match_en & mdl_vld[L-1]);
   assign ru_out_rule_data = mdl_dat[L-1];

   typedef struct {
      logic [N-1:0] vld;
      logic [N-1:0] exp_rdy;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [W-1:0] rule, input logic last);
      req_valid[i]             = v;
      req_rule_data[i*W +: W]  = rule;
      req_last[i]              = last;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      req_valid     = '0;
      req_last      = '0;
      req_rule_data = '0;
      match_en      = 1'b0;
      force_match   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, dones, done_k, exp_idx;
      logic [W-1:0] exp_dat;

      // Round-robin vectors: continuous valids rotate 0..3, sparse valids resume after last grant.
      tbl[0]  = '{4'hF, 4'h1};
      tbl[1]  = '{4'hF, 4'h2};
      tbl[2]  = '{4'hF, 4'h4};
      tbl[3]  = '{4'hF, 4'h8};
      tbl[4]  = '{4'hF, 4'h1};
      tbl[5]  = '{4'hF, 4'h2};
      tbl[6]  = '{4'h5, 4'h4};
      tbl[7]  = '{4'h3, 4'h1};
      tbl[8]  = '{4'h8, 4'h8};
      tbl[9]  = '{4'hA, 4'h2};
      tbl[10] = '{4'h0, 4'h0};
      tbl[11] = '{4'hF, 4'h4};

      for (int i = 0; i < N; i++) begin
         req_src_port[i*16 +: 16] = 16'(1000 + i);
         req_dst_port[i*16 +: 16] = 16'(2000 + i);
      end
      req_tcp = 4'b0100;

      // Reset state, with all requesters asserting valid.
      rst = 1'b1; req_valid = '1; req_last = '0; req_rule_data = '0;
      tick(); tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_ru_valid", ru_rule_valid, 0);
      chk("rst_ru_data", ru_rule_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_rule_data, 0);
      chk("rst_rsp_done", rsp_done, 0);
      chk("rst_err", err_orphan, 0);

      // Table-driven round-robin, also checking the issue register one cycle later.
      do_reset();
      for (int i = 0; i < N; i++) req_rule_data[i*W +: W] = W'(16'h10 + i);
      for (int r = 0; r < 12; r++) begin
         req_valid = tbl[r].vld;
         #1;
         chk($sformatf("rr_ready[%0d]", r), req_ready, tbl[r].exp_rdy);
         exp_idx = 0;
         if (r > 0)
            for (int b = 0; b < N; b++) if (tbl[r-1].exp_rdy[b]) exp_idx = b;
         exp_dat = W'(16'h10 + exp_idx);
         if (r > 0 && tbl[r-1].exp_rdy != 0) begin
            chk($sformatf("rr_ru_valid[%0d]", r), ru_rule_valid, 1);
            chk($sformatf("rr_ru_data[%0d]", r), ru_rule_data, exp_dat);
         end else begin
            chk($sformatf("rr_ru_valid[%0d]", r), ru_rule_valid, 0);
            chk($sformatf("rr_ru_data[%0d]", r), ru_rule_data, 0);
         end
         tick();
      end

      // Single beat from requester 2, rule 0x05, matched: response at T+19.
      do_reset();
      match_en = 1'b1;
      set_req(2, 1'b1, 16'h05, 1'b1);
      #1;
      chk("single_grant", req_ready, 4'h4);
      tick();
      set_req(2, 1'b0, 16'h00, 1'b0);
      chk("single_ru_valid", ru_rule_valid, 1);
      chk("single_ru_data", ru_rule_data, 16'h05);
      chk("single_ru_ports", {ru_src_port, ru_dst_port, 15'h0, ru_tcp}, {16'd1002, 16'd2002, 16'h1});
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 19) begin
            chk("single_rsp_valid", rsp_valid, 4'h4);
            chk("single_rsp_data", rsp_rule_data, 64'h0000_0005_0000_0000);
            chk("single_rsp_done", rsp_done, 4'h4);
         end else if (rsp_valid != 0 || rsp_done != 0 || rsp_rule_data != 0) begin
            bad++;
         end
      end
      chk("single_quiet_cycles", bad, 0);

      // Requester 1 drains its last beat while requester 0 streams; 1 is blocked until done+1.
      do_reset();
      match_en = 1'b1;
      set_req(1, 1'b1, 16'h21, 1'b1);
      #1;
      chk("drain_first_grant", req_ready, 4'h2);
      tick();
      set_req(0, 1'b1, 16'h30, 1'b0);
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
         #1;
         if (req_ready != 4'h1) bad++;
         if (k == 20) begin
            chk("drain_done", rsp_done, 4'h2);
            chk("drain_rsp_valid", rsp_valid, 4'h2);
            chk("drain_rsp_data", rsp_rule_data[W +: W], 16'h21);
         end else if (rsp_done != 0) begin
            bad++;
         end
         tick();
      end
      chk("drain_blocked_cycles", bad, 0);
      #1;
      chk("drain_regrant", req_ready, 4'h2);
      chk("drain_req0_rsp", rsp_valid, 4'h1);
      chk("drain_req0_data", rsp_rule_data[W-1:0], 16'h30);
      req_valid = '0;
      tick();

      // Null rule then 0x07 (last), no match: no rsp_valid, one rsp_done at issue(0x07)+19.
      do_reset();
      set_req(0, 1'b1, 16'h00, 1'b0);
      #1;
      chk("null_grant0", req_ready, 4'h1);
      tick();
      set_req(0, 1'b1, 16'h07, 1'b1);
      #1;
      chk("null_grant1", req_ready, 4'h1);
      chk("null_issued_valid", ru_rule_valid, 1);
      chk("null_issued_data", ru_rule_data, 0);
      tick();
      set_req(0, 1'b0, 16'h00, 1'b0);
      chk("null_issue7", ru_rule_data, 16'h07);
      bad = 0; dones = 0; done_k = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (rsp_valid != 0) bad++;
         if (rsp_done[0]) begin dones++; done_k = k; end
         if (rsp_done[3:1] != 0) bad++;
      end
      chk("null_no_rsp_valid", bad, 0);
      chk("null_done_count", dones, 1);
      chk("null_done_cycle", done_k, 19);

      // Reset mid-flight: three beats issued, rst one cycle at first issue+5.
      do_reset();
      match_en = 1'b1;
      set_req(0, 1'b1, 16'h11, 1'b0); tick();
      set_req(0, 1'b1, 16'h12, 1'b0); tick();
      set_req(0, 1'b1, 16'h13, 1'b1); tick();
      set_req(0, 1'b0, 16'h00, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_err_clear", err_orphan, 0);
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         if (rsp_valid != 0 || rsp_done != 0) bad++;
         tick();
      end
      chk("midrst_no_rsp", bad, 0);
      chk("midrst_err_set", err_orphan, 1);
      set_req(0, 1'b1, 16'h01, 1'b0);
      #1;
      chk("midrst_fsm_idle", req_ready, 4'h1);
      req_valid = '0;
      tick();

      // Orphan match with nothing issued: sticky until reset.
      do_reset();
      chk("orphan_pre", err_orphan, 0);
      force_match = 1'b1;
      tick();
      force_match = 1'b0;
      chk("orphan_set", err_orphan, 1);
      chk("orphan_no_rsp", rsp_valid, 0);
      for (int k = 0; k < 5; k++) tick();
      chk("orphan_sticky", err_orphan, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("orphan_cleared", err_orphan, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rule_unit_arb.md
RULE_UNIT_ARB -- requirements
Module: rule_unit_arb

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_REQ, default 4, number of rule requesters sharing one rule_unit.
- RULE_AWIDTH, default from struct_s, rule ID width.
- LATENCY, default 18, cycles from ru_rule_valid high to the matching ru_rule_pg_match/ru_out_rule_data.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accepted (grant).
- req_rule_data  in  NUM_REQ*RULE_AWIDTH  rule ID per requester; 0 = null rule.
- req_src_port  in  NUM_REQ*16  packet source port.
- req_dst_port  in  NUM_REQ*16  packet destination port.
- req_tcp  in  NUM_REQ  packet is TCP.
- req_last  in  NUM_REQ  final beat of the requester's packet.
- ru_rule_data  out  RULE_AWIDTH  to rule_unit in_rule_data.
- ru_rule_valid  out  1  to rule_unit in_rule_valid.
- ru_src_port / ru_dst_port  out  16 each  to rule_unit.
- ru_tcp  out  1  to rule_unit.
- ru_out_rule_data  in  RULE_AWIDTH  from rule_unit out_rule_data.
- ru_rule_pg_match  in  1  from rule_unit rule_pg_match.
- rsp_valid  out  NUM_REQ  matched rule returned to requester i (no backpressure).
- rsp_rule_data  out  NUM_REQ*RULE_AWIDTH  matched rule ID.
- rsp_done  out  NUM_REQ  one-cycle pulse: all beats of requester i's packet resolved.
- err_orphan  out  1  sticky: match arrived with no valid tag.

Function
REQ-003 Handshake: beat transfers on cycle where req_valid[i] & req_ready[i]; at most one req_ready bit high per cycle.
REQ-004 Per-requester FSM: IDLE -> ACTIVE on accepted beat with req_last=0; IDLE/ACTIVE -> DRAIN on accepted beat with req_last=1; DRAIN -> IDLE on cycle rsp_done[i] pulses.
REQ-005 Requester in DRAIN SHALL NOT be eligible for grant (req_ready[i]=0).
REQ-006 Arbitration: round-robin among eligible requesters with req_valid; search starts at index (last_grant+1) mod NUM_REQ; last_grant updates only on a transfer.
REQ-007 Issue register: accepted beat drives ru_* on next cycle T with ru_rule_valid=1; otherwise ru_rule_valid=0 and ru_rule_data=0.
REQ-008 Null rules (rule_data=0) SHALL be issued and tagged like any beat.
REQ-009 Tag pipeline: LATENCY-stage shift register of {valid, id[$clog2(NUM_REQ)-1:0], last}, loaded at cycle T from issued beat, emerging at T+LATENCY.
REQ-010 At emergence cycle E with valid tag: if ru_rule_pg_match, rsp_valid[id]=1 and rsp_rule_data[id]=ru_out_rule_data at E+1; if tag.last, rsp_done[id]=1 at E+1 (same cycle as any rsp_valid for that beat).
REQ-011 rsp_valid and rsp_done SHALL be single-cycle; rsp_rule_data lanes SHALL be 0 when their rsp_valid is 0.
REQ-012 ru_rule_pg_match=1 at cycle with invalid emerging tag SHALL set err_orphan and produce no response.
REQ-013 Throughput: one beat per cycle aggregate; a requester accepted at cycle N is eligible again at N+1 unless in DRAIN.
REQ-014 Requester entering DRAIN and unrelated requesters' grants SHALL proceed concurrently; response order per requester equals issue order.

Reset
REQ-015 While rst=1: req_ready=0, ru_rule_valid=0, ru_* data 0, rsp_valid=0, rsp_rule_data=0, rsp_done=0, err_orphan=0, all FSMs IDLE, last_grant=NUM_REQ-1, all tag valid bits 0.
REQ-016 Reset mid-operation SHALL discard in-flight tags; results arriving after rst deassertion for pre-reset beats SHALL NOT produce rsp_valid/rsp_done and SHALL NOT set err_orphan only if ru_rule_pg_match=0 (a match sets err_orphan).
REQ-017 First grant after reset SHALL go to requester 0 if valid.

Verification
REQ-018 Single beat: req 2 sends rule 0x05, last=1, rule_unit model matches -> ru_rule_valid at T, rsp_valid[2]=1 with 0x05 and rsp_done[2]=1 at T+19.
REQ-019 Round-robin: all 4 requesters hold valid continuously, no last -> grants 0,1,2,3,0,1 on consecutive cycles.
REQ-020 DRAIN block: req 1 sends last beat at cycle N, keeps req_valid -> req_ready[1]=0 until rsp_done[1]; next grant to req 1 no earlier than done cycle +1.
REQ-021 Null/no-match: req 0 sends rules 0x00 then 0x07(last), model no match -> no rsp_valid[0], rsp_done[0] pulses once at issue(0x07)+19.
REQ-022 Reset mid-flight: 3 beats issued, rst pulsed 1 cycle at issue+5 -> no rsp_valid/rsp_done afterward, FSMs IDLE, err_orphan=1 if model still returns a match.
REQ-023 Orphan: inject ru_rule_pg_match=1 with no beat issued -> err_orphan=1 next cycle, stays 1 until rst.
